sccb_cmd_arbiter: RTL and testbench
===================================

# sccb_cmd_arbiter

Shares the single SCCB/I2C command sender between several register-write requesters: the power-up configuration sequencer, runtime exposure/gain tuning, and debug writes. The block grants requesters round-robin and latches the winner's {register, value} word. It presents that word to the sender's send/taken handshake, then enforces an inter-command gap. After a soft-reset write (COM7 = 0x12 with bit 7 set) the gap is extended so the camera can reset. It sits between the requesters and the sender; the camera device ID is added downstream.

## Interface
- NUM_REQ, 2: number of requesters (1..8)
- GAP_CYCLES, 256: idle cycles after each accepted command (≥1)
- RESET_WAIT_CYCLES, 250000: gap after a COM7 soft-reset write (10 ms at 25 MHz, ≥1)
- CNT_W, 18: gap counter width; must hold max(GAP_CYCLES, RESET_WAIT_CYCLES)−1
- clk  in  1  system clock (25 MHz, same clock as the sender)
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester write request, level
- lock  in  NUM_REQ  requester i keeps priority for its next command (burst)
- cmd  in  16*NUM_REQ  flat {register[15:8], value[7:0]} per requester; requester i at [16i+15:16i]
- ack  out  NUM_REQ  one-cycle pulse: requester i's command was taken by the sender
- busy  out  1  high whenever state ≠ IDLE
- snd_send  out  1  command valid to the sender
- snd_register  out  8  latched register address
- snd_value  out  8  latched register value
- snd_taken  in  1  sender accepted the command (single-cycle pulse)

## Operation
- FSM states: IDLE, ISSUE, GAP.
- **IDLE**
  - If any req is high, select the winner: the first set bit at or after ptr, in circular order.
  - Latch the winner's cmd into snd_register/snd_value and store the grant index. Next state is ISSUE.
  - If no req is high, stay in IDLE.
- **ISSUE**
  - snd_send = 1 and the latched outputs are held stable.
  - When snd_taken = 1:
    - pulse ack[grant] on the next cycle;
    - load the counter with RESET_WAIT_CYCLES−1 if snd_register = 0x12 and snd_value[7] = 1, else GAP_CYCLES−1;
    - next state is GAP.
- **GAP**
  - Decrement the counter each cycle. When the counter equals 0, next state is IDLE.
  - Also update ptr on that transition: ptr = grant if lock[grant] is high, else (grant+1) mod NUM_REQ.
- Requester rule: hold req and cmd stable until ack. A req still high after ack is treated as a new command, so cmd must already show the next word.
- req dropping during ISSUE or GAP does not abort the transaction. The latched command is still issued and ack still pulses.
- snd_taken in IDLE or GAP is ignored.
- lock sampled low while its requester is not granted has no effect.
- Reset, asynchronous and effective mid-transaction:
  - state = IDLE, ptr = 0, counter = 0;
  - snd_send = 0, snd_register = 0, snd_value = 0;
  - ack = 0, busy = 0.
  - An in-flight command is dropped without ack; the requester re-requests after reset.

## Timing
- All outputs are registered.
- req high in IDLE at cycle t gives snd_send = 1 and valid register/value at t+1.
- snd_taken at cycle k:
  - snd_send = 0, ack pulse and GAP all begin at k+1;
  - GAP occupies exactly N cycles (k+1..k+N, N = the selected gap);
  - IDLE at k+N+1; the earliest next snd_send is at k+N+2.
- snd_taken arriving in the same cycle snd_send first rises is legal and is honoured.
- Maximum snd_send hold time is unbounded; the arbiter waits on the sender indefinitely.
- With all requesters continuously requesting and lock low, grants rotate 0,1,…,NUM_REQ−1,0.

## Structure
- Package sccb_pkg holds:
  - the state enum {IDLE, ISSUE, GAP};
  - constants COM7_ADDR = 8'h12 and COM7_RESET_BIT = 7;
  - default gap constants.
- Sub-module sccb_rr_pick: a combinational round-robin picker. Inputs are req and ptr; outputs are a one-hot grant, the grant index and any_req.
- The top-level holds the FSM, command latch and gap counter. The expected size is about 200 lines.

## Test plan
- **Single write:** NUM_REQ=2, GAP_CYCLES=4; req[0]=1 with cmd0=16'h1204. Sender model asserts taken 3 cycles after snd_send. Required: snd_register=0x12, snd_value=0x04, ack[0] pulses once, busy high for exactly 3+4+1 cycles, then the next snd_send 6 cycles after taken.
- **Soft-reset gap:** cmd0=16'h1280, RESET_WAIT_CYCLES=20. Required: 20 GAP cycles before returning to IDLE; a pending req[1] with 16'h1100 is issued at taken+22.
- **Round-robin:** both req held high, lock=0, cmds 16'h0101 and 16'h0202. Required: issue order 0101, 0202, 0101, 0202; each ack goes to the matching requester.
- **Lock burst:** req=2'b11, lock[0]=1 for 3 commands, then 0. Required: requester 0 is granted 3 times in a row, then requester 1.
- **Drop/ignore:** req[1] falls during ISSUE → the command is still issued and ack[1] pulses. A spurious snd_taken in GAP → no ack and no state change.
- **Reset mid-operation:** rst_n low while in ISSUE. Required: snd_send=0, busy=0 and ack=0 immediately (asynchronously), with no ack pulse. After release, req[0] is re-granted (ptr=0).

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB command arbiter.
package sccb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    localparam logic [7:0] COM7_ADDR      = 8'h12;
    localparam int         COM7_RESET_BIT = 7;

    localparam int DEF_GAP_CYCLES        = 256;
    localparam int DEF_RESET_WAIT_CYCLES = 250000;
    localparam int DEF_CNT_W             = 18;

endpackage

// File: rtl/sccb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
module sccb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    logic [IDX_W:0] pos;
    logic           found;

    assign any_req = |req;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                     = 1'b1;
                gnt_oh[pos[IDX_W-1:0]]    = 1'b1;
                gnt_idx                   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter feeding one SCCB sender, with post-command gap
// and an extended gap after a COM7 soft-reset write.
module sccb_cmd_arbiter
    import sccb_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int GAP_CYCLES        = DEF_GAP_CYCLES,
    parameter int RESET_WAIT_CYCLES = DEF_RESET_WAIT_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   lock,
    input  logic [16*NUM_REQ-1:0] cmd,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic                 snd_send,
    output logic [7:0]           snd_register,
    output logic [7:0]           snd_value,
    input  logic                 snd_taken
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RESET_WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, ptr_next;
    logic [IDX_W-1:0]     grant_q, pick_idx;
    logic [NUM_REQ-1:0]   grant_oh_q, pick_oh;
    logic                 any_req;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          cmd_sel;
    logic                 soft_rst;
    logic                 send_d, busy_d;
    logic [NUM_REQ-1:0]   ack_d;

    sccb_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) cmd_sel = cmd_sel | cmd[16*i +: 16];
        end
    end

    assign soft_rst = (snd_register == COM7_ADDR) &&
                      snd_value[COM7_RESET_BIT];

    assign ptr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ?
                      '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (snd_taken) state_d = GAP;
            GAP:     if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        send_d = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
        ack_d  = (state_q == ISSUE && snd_taken) ? grant_oh_q : '0;
    end

    // Lock keeps the pointer on the current winner for its next command.
    always_comb begin
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        unique case (state_q)
            ISSUE: if (snd_taken) cnt_d = soft_rst ? RST_LD : GAP_LD;
            GAP: begin
                if (cnt_q == '0) begin
                    ptr_d = |(lock & grant_oh_q) ? grant_q : ptr_next;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            grant_oh_q   <= '0;
            snd_register <= '0;
            snd_value    <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (state_q == IDLE && any_req) begin
                grant_q      <= pick_idx;
                grant_oh_q   <= pick_oh;
                snd_register <= cmd_sel[15:8];
                snd_value    <= cmd_sel[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_send <= 1'b0;
            busy     <= 1'b0;
            ack      <= '0;
        end else begin
            snd_send <= send_d;
            busy     <= busy_d;
            ack      <= ack_d;
        end
    end

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Scoreboard bench: transaction-level model predicts per-cycle
// busy/send/ack, issued words and ack owners.
module tb_sccb_cmd_arbiter;

    localparam int N  = 2;
    localparam int GP = 4;
    localparam int RW = 20;
    localparam int QD = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [16*N-1:0] cmd = '0;
    logic [N-1:0]   ack;
    logic           busy, snd_send;
    logic [7:0]     snd_register, snd_value;
    logic           snd_taken = 1'b0;

    always #5 clk = ~clk;

    sccb_cmd_arbiter #(
        .NUM_REQ           (N),
        .GAP_CYCLES        (GP),
        .RESET_WAIT_CYCLES (RW),
        .CNT_W             (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .lock         (lock),
        .cmd          (cmd),
        .ack          (ack),
        .busy         (busy),
        .snd_send     (snd_send),
        .snd_register (snd_register),
        .snd_value    (snd_value),
        .snd_taken    (snd_taken)
    );

    typedef struct {
        logic         send;
        logic         busy;
        logic [N-1:0] ack;
    } cyc_t;

    typedef struct {
        logic [15:0] word;
        int          idx;
    } txn_t;

    cyc_t cyc_q[$];
    txn_t txn_q[$];
    int   ack_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;

    logic [15:0] rq [N][QD];
    int   rh [N];
    int   rt [N];

    int   c = 0;
    bit   m_issuing = 0;
    int   m_gap_end = -1;
    int   m_ptr = 0;
    int   m_win = 0;
    logic [15:0] m_word = '0;
    int   m_gcnt [N];

    int   tk_wait = 0, tk_delay = 3, dmin = 3, dmax = 3;
    bit   spur_en = 0, drop_en = 0, rel_pending = 0;
    int   lock_pct = 0;
    logic [N-1:0] lock_force = '0;
    logic [N-1:0] drop = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(9) == 0) w[15:8] = 8'h12;
        return w;
    endfunction

    function automatic int qlen(int i);
        return (rt[i] - rh[i] + QD) % QD;
    endfunction

    task automatic push_cmd(int i, logic [15:0] w);
        if (qlen(i) < QD - 8) begin
            rq[i][rt[i]] = w;
            rt[i] = (rt[i] + 1) % QD;
        end
    endtask

    // Drives requesters/sender for this cycle and predicts next cycle.
    task automatic step();
        logic [N-1:0] a;
        logic         tk;
        int           gap;
        int           j;
        bit           found;
        cyc_t         e;
        @(negedge clk);
        c++;
        if (rel_pending) begin
            rst_n = 1'b1;
            mon_en = 1;
            rel_pending = 0;
        end
        a = ack;
        drop = '0;
        if (drop_en && m_issuing && $urandom_range(1) == 1)
            drop = N'(1) << m_win;
        for (int i = 0; i < N; i++) begin
            if (rst_n && a[i] && qlen(i) > 0) rh[i] = (rh[i] + 1) % QD;
            req[i] = (qlen(i) > 0) && !drop[i];
            cmd[16*i +: 16] = rq[i][rh[i]];
            lock[i] = lock_force[i] ||
                      ($urandom_range(99) < lock_pct);
        end
        tk = 1'b0;
        if (snd_send) begin
            if (tk_wait >= tk_delay) begin
                tk = 1'b1;
                tk_wait = 0;
                tk_delay = $urandom_range(dmax, dmin);
            end else begin
                tk_wait++;
            end
        end else begin
            tk_wait = 0;
            if (spur_en && $urandom_range(5) == 0) tk = 1'b1;
        end
        snd_taken = tk;
        if (rst_n) begin
            e.ack = '0;
            if (m_issuing && tk) begin
                e.ack = N'(1) << m_win;
                ack_q.push_back(m_win);
                gap = (m_word[15:8] == 8'h12 && m_word[7]) ? RW : GP;
                m_gap_end = c + gap;
                m_issuing = 0;
            end
            if (!m_issuing && c == m_gap_end)
                m_ptr = lock[m_win] ? m_win : (m_win + 1) % N;
            if (!m_issuing && c > m_gap_end && req != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && req[j]) begin
                        found = 1;
                        m_win = j;
                    end
                end
                m_word = cmd[16*m_win +: 16];
                txn_q.push_back('{m_word, m_win});
                m_gcnt[m_win]++;
                m_issuing = 1;
            end
            e.send = m_issuing;
            e.busy = m_issuing || (c + 1 <= m_gap_end);
            cyc_q.push_back(e);
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = !m_issuing && (c > m_gap_end);
        for (int i = 0; i < N; i++) if (qlen(i) != 0) r = 0;
        return r;
    endfunction

    task automatic drain(string name, int bound);
        int n;
        n = 0;
        while (!all_idle() && n < bound) begin
            step();
            n++;
        end
        total++;
        if (n >= bound) begin
            bad++;
            $display("FAIL %s: drain got %0d cycles, expected < %0d",
                     name, n, bound);
        end
    endtask

    task automatic set_delay(int lo, int hi);
        dmin = lo;
        dmax = hi;
        tk_delay = $urandom_range(hi, lo);
    endtask

    initial begin : monitor
        cyc_t        e;
        txn_t        t;
        int          a;
        logic [15:0] cur;
        logic        prev_send;
        prev_send = 1'b0;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                prev_send = 1'b0;
            end else begin
                if (cyc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cyc: got no prediction, expected one");
                end else begin
                    e = cyc_q.pop_front();
                    chk("snd_send", 32'(snd_send), 32'(e.send));
                    chk("busy", 32'(busy), 32'(e.busy));
                    chk("ack", 32'(ack), 32'(e.ack));
                end
                if (snd_send && !prev_send) begin
                    if (txn_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word: got %0h, expected none",
                                 {snd_register, snd_value});
                    end else begin
                        t = txn_q.pop_front();
                        cur = t.word;
                        chk("word", 32'({snd_register, snd_value}),
                            32'(t.word));
                    end
                end else if (snd_send) begin
                    chk("hold", 32'({snd_register, snd_value}), 32'(cur));
                end
                if (ack != '0) begin
                    if (ack_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ack_owner: got %0b, expected none",
                                 ack);
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_owner", 32'(ack), 32'(N'(1) << a));
                    end
                end
                prev_send = snd_send;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int g0;
        for (int i = 0; i < N; i++) begin
            rh[i] = 0;
            rt[i] = 0;
            m_gcnt[i] = 0;
        end
        repeat (2) step();
        chk("rst_send", 32'(snd_send), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_reg", 32'({snd_register, snd_value}), 32'd0);
        rel_pending = 1;

        // single write, then soft-reset gap with a pending request
        set_delay(3, 3);
        push_cmd(0, 16'h1204);
        drain("single", 100);
        push_cmd(1, 16'h1280);
        n = 0;
        while (!m_issuing && n < 20) begin
            step();
            n++;
        end
        push_cmd(0, 16'h1100);
        drain("softrst", 200);

        // round-robin with all requesters busy
        set_delay(0, 3);
        for (int k = 0; k < 4; k++) begin
            push_cmd(0, 16'h0101);
            push_cmd(1, 16'h0202);
        end
        drain("rr", 400);

        // lock burst on requester 0
        for (int k = 0; k < 5; k++) push_cmd(0, rand_word());
        for (int k = 0; k < 3; k++) push_cmd(1, rand_word());
        lock_force = 2'b01;
        g0 = m_gcnt[0];
        n = 0;
        while (m_gcnt[0] - g0 < 3 && n < 500) begin
            step();
            n++;
        end
        lock_force = '0;
        drain("lock", 1000);

        // dropped requests and spurious taken
        drop_en = 1;
        spur_en = 1;
        for (int k = 0; k < 6; k++) push_cmd(k % N, rand_word());
        drain("drop", 1000);
        drop_en = 0;
        spur_en = 0;

        // asynchronous reset while requester 1 is in ISSUE
        set_delay(10, 10);
        push_cmd(1, 16'h3344);
        n = 0;
        while (!snd_send && n < 20) begin
            step();
            n++;
        end
        chk("rst_setup", 32'(snd_send), 32'd1);
        push_cmd(0, 16'h5566);
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mon_en = 0;
        #1;
        chk("async_send", 32'(snd_send), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ack", 32'(ack), 32'd0);
        cyc_q.delete();
        txn_q.delete();
        ack_q.delete();
        m_issuing = 0;
        m_gap_end = -1;
        m_ptr = 0;
        repeat (2) step();
        rel_pending = 1;
        set_delay(0, 4);
        drain("after_rst", 500);

        // random traffic
        lock_pct = 20;
        spur_en = 1;
        drop_en = 1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(2) == 0)
                push_cmd($urandom_range(N - 1), rand_word());
            step();
        end
        lock_pct = 0;
        drain("random", 5000);

        step();
        @(posedge clk);
        #2;
        chk("cyc_left", 32'(cyc_q.size()), 32'd0);
        chk("txn_left", 32'(txn_q.size()), 32'd0);
        chk("ack_left", 32'(ack_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
